// File: rtl/mod_counter_pkg.sv
// mod_counter_pkg: mode and FSM state types shared by the modulo counter files
package mod_counter_pkg;
  typedef enum logic [1:0] {MODE_WRAP, MODE_SAT, MODE_ONESHOT, MODE_RSVD} mode_t;
  typedef enum logic {ST_RUN, ST_DONE} state_t;
endpackage

// File: rtl/mod_counter_prescaler.sv
// mod_counter_prescaler: divides enable cycles by PRESCALE_DIV, tick on the last one
module mod_counter_prescaler #(
  parameter int PRESCALE_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic enable,
  output logic tick
);
  localparam int W = PRESCALE_DIV > 1 ? $clog2(PRESCALE_DIV) : 1;
  logic [W-1:0] phase;
  assign tick = enable && phase == W'(PRESCALE_DIV - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) phase <= '0;
    else if (clr) phase <= '0;
    else if (enable) phase <= tick ? '0 : phase + 1'b1;
endmodule

// File: rtl/mod_counter.sv
// mod_counter: programmable modulo counter with wrap/saturate/one-shot modes.
// Define MOD_COUNTER_PRESCALE_EN to step only every PRESCALE_DIV enabled cycles.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int PRESCALE_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             sync_clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dir_up,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] max_value,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap_pulse,
  output logic             done
);
  mode_t       md;
  state_t      state;
  logic        tick, step, wrap_mode, rst_n;
  logic [1:0]  rst_q;
  // reset asserts asynchronously but is released on a clock edge
  always_ff @(posedge clk or negedge rst)
    if (!rst) rst_q <= '0;
    else rst_q <= {rst_q[0], 1'b1};
  assign rst_n = rst_q[1];
  assign md = mode_t'(mode);
  assign wrap_mode = md == MODE_WRAP || md == MODE_RSVD;
  assign tc = dir_up ? count >= max_value : count == '0;
  assign step = enable && tick && state == ST_RUN;
  assign done = state == ST_DONE;
`ifdef MOD_COUNTER_PRESCALE_EN
  mod_counter_prescaler #(.PRESCALE_DIV(PRESCALE_DIV)) u_prescaler (
    .clk    (clk),
    .rst    (rst_n),
    .clr    (sync_clr || load),
    .enable (enable && state == ST_RUN),
    .tick   (tick)
  );
`else
  assign tick = PRESCALE_DIV >= 1;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count      <= '0;
      wrap_pulse <= 1'b0;
      state      <= ST_RUN;
    end else begin
      wrap_pulse <= 1'b0;
      if (sync_clr) begin
        count <= '0;
        state <= ST_RUN;
      end else if (load) begin
        count <= load_value > max_value ? max_value : load_value;
        state <= ST_RUN;
      end else if (state == ST_DONE) begin
        if (md != MODE_ONESHOT) state <= ST_RUN;
      end else if (step) begin
        if (!tc) count <= dir_up ? count + 1'b1 : count - 1'b1;
        else if (wrap_mode) begin
          count      <= dir_up ? '0 : max_value;
          wrap_pulse <= 1'b1;
        end else if (md == MODE_ONESHOT) state <= ST_DONE;
      end
    end
endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: vector table and scoreboard bench for mod_counter at WIDTH=4
module tb_mod_counter;
  typedef struct {
    string      nm;
    logic       sc, ld;
    logic [3:0] lv;
    logic       en, up;
    logic [1:0] md;
    logic [3:0] mx, ec;
    logic       etc, ew, ed;
  } vec_t;

  logic       clk = 0, rst = 0, enable = 0, sync_clr = 0, load = 0, dir_up = 1;
  logic [3:0] load_value = 0, max_value = 9, count;
  logic [1:0] mode = 0;
  logic       tc, wrap_pulse, done;
  int         n_chk = 0, n_fail = 0;
  vec_t       tbl[$], sb[$];

  mod_counter #(.WIDTH(4), .PRESCALE_DIV(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sync_clr(sync_clr), .load(load),
    .load_value(load_value), .dir_up(dir_up), .mode(mode), .max_value(max_value),
    .count(count), .tc(tc), .wrap_pulse(wrap_pulse), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(string nm, logic sc, logic ld, logic [3:0] lv, logic en,
                              logic up, logic [1:0] md, logic [3:0] mx, logic [3:0] ec,
                              logic etc, logic ew, logic ed);
    vec_t t;
    t.nm = nm; t.sc = sc; t.ld = ld; t.lv = lv; t.en = en; t.up = up; t.md = md;
    t.mx = mx; t.ec = ec; t.etc = etc; t.ew = ew; t.ed = ed;
    return t;
  endfunction

  task automatic drive(vec_t t);
    vec_t e;
    sync_clr = t.sc; load = t.ld; load_value = t.lv; enable = t.en;
    dir_up = t.up; mode = t.md; max_value = t.mx;
    sb.push_back(t);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.nm, ".count"}, int'(count), int'(e.ec));
    check({e.nm, ".tc"}, int'(tc), int'(e.etc));
    check({e.nm, ".wrap"}, int'(wrap_pulse), int'(e.ew));
    check({e.nm, ".done"}, int'(done), int'(e.ed));
  endtask

  task automatic idle3();
    for (int i = 0; i < 3; i++) drive(mk("idle", 0, 0, 0, 0, 1, 0, 9, 0, 0, 0, 0));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset.count", int'(count), 0);
    check("reset.wrap", int'(wrap_pulse), 0);
    check("reset.done", int'(done), 0);
    check("reset.tc", int'(tc), 0);
    rst = 1;
    idle3();
`ifdef MOD_COUNTER_PRESCALE_EN
    tbl.push_back(mk("pre_clr", 1, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0));
    for (int i = 1; i <= 12; i++)
      tbl.push_back(mk("pre_run", 0, 0, 0, 1, 1, 0, 2, 4'((i / 4) % 3), (i / 4) % 3 == 2, i == 12, 0));
    for (int i = 0; i < 2; i++) tbl.push_back(mk("pre_ph", 0, 0, 0, 1, 1, 0, 2, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk("pre_stall", 0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0));
    tbl.push_back(mk("pre_ph3", 0, 0, 0, 1, 1, 0, 2, 0, 0, 0, 0));
    tbl.push_back(mk("pre_tick", 0, 0, 0, 1, 1, 0, 2, 1, 0, 0, 0));
    for (int i = 0; i < 2; i++) tbl.push_back(mk("pre_ph2", 0, 0, 0, 1, 1, 0, 2, 1, 0, 0, 0));
    tbl.push_back(mk("pre_load", 0, 1, 0, 1, 1, 0, 2, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk("pre_after_ld", 0, 0, 0, 1, 1, 0, 2, 0, 0, 0, 0));
    tbl.push_back(mk("pre_ld_tick", 0, 0, 0, 1, 1, 0, 2, 1, 0, 0, 0));
    foreach (tbl[i]) drive(tbl[i]);
`else
    // wrap up to 9, twice around
    for (int i = 1; i <= 20; i++)
      tbl.push_back(mk("wrap_up", 0, 0, 0, 1, 1, 0, 9, 4'(i % 10), i % 10 == 9, i % 10 == 0, 0));
    tbl.push_back(mk("sat_load", 0, 1, 5, 1, 0, 1, 15, 5, 0, 0, 0));
    for (int i = 1; i <= 7; i++)
      tbl.push_back(mk("sat_down", 0, 0, 0, 1, 0, 1, 15, 4'(i <= 5 ? 5 - i : 0), i >= 5, 0, 0));
    tbl.push_back(mk("os_clr", 1, 0, 0, 1, 1, 2, 3, 0, 0, 0, 0));
    tbl.push_back(mk("os_1", 0, 0, 0, 1, 1, 2, 3, 1, 0, 0, 0));
    tbl.push_back(mk("os_2", 0, 0, 0, 1, 1, 2, 3, 2, 0, 0, 0));
    tbl.push_back(mk("os_3", 0, 0, 0, 1, 1, 2, 3, 3, 1, 0, 0));
    tbl.push_back(mk("os_done", 0, 0, 0, 1, 1, 2, 3, 3, 1, 0, 1));
    tbl.push_back(mk("os_hold", 0, 0, 0, 1, 1, 2, 3, 3, 1, 0, 1));
    tbl.push_back(mk("os_load_clamp", 0, 1, 7, 0, 1, 2, 3, 3, 1, 0, 0));
    tbl.push_back(mk("os_redone", 0, 0, 0, 1, 1, 2, 3, 3, 1, 0, 1));
    tbl.push_back(mk("os_exit_mode", 0, 0, 0, 0, 1, 1, 3, 3, 1, 0, 0));
    tbl.push_back(mk("ld6", 0, 1, 6, 0, 1, 0, 9, 6, 0, 0, 0));
    tbl.push_back(mk("clr_over_ld", 1, 1, 5, 1, 1, 0, 9, 0, 0, 0, 0));
    tbl.push_back(mk("ld9", 0, 1, 9, 0, 1, 0, 9, 9, 1, 0, 0));
    tbl.push_back(mk("max_lower", 0, 0, 0, 0, 1, 0, 4, 9, 1, 0, 0));
    tbl.push_back(mk("over_max_wrap", 0, 0, 0, 1, 1, 0, 4, 0, 0, 1, 0));
    tbl.push_back(mk("pulse_clear", 0, 0, 0, 0, 1, 0, 4, 0, 0, 0, 0));
    tbl.push_back(mk("max0_up_a", 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk("max0_up_b", 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk("max0_down", 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk("dn_ld1", 0, 1, 1, 0, 0, 0, 9, 1, 0, 0, 0));
    tbl.push_back(mk("dn_0", 0, 0, 0, 1, 0, 0, 9, 0, 1, 0, 0));
    tbl.push_back(mk("dn_wrap", 0, 0, 0, 1, 0, 0, 9, 9, 0, 1, 0));
    tbl.push_back(mk("rsvd_wrap", 0, 0, 0, 1, 1, 3, 9, 0, 0, 1, 0));
    tbl.push_back(mk("rs_ld7", 0, 1, 7, 0, 1, 2, 7, 7, 1, 0, 0));
    tbl.push_back(mk("rs_done", 0, 0, 0, 1, 1, 2, 7, 7, 1, 0, 1));
    foreach (tbl[i]) drive(tbl[i]);
    // asynchronous reset between edges clears outputs without a clock
    #2 rst = 0;
    #1;
    check("async_rst.count", int'(count), 0);
    check("async_rst.wrap", int'(wrap_pulse), 0);
    check("async_rst.done", int'(done), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    idle3();
    drive(mk("restart", 0, 0, 0, 1, 1, 0, 9, 1, 0, 0, 0));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
